// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags for the out-of-order core.
// Decode reads operands and renames destinations; commit retires values and clears renames.
module reg_file #(
  parameter int unsigned REG_NUM   = 32,
  parameter int unsigned REG_POS_W = 5,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ROB_POS_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  input  logic                 rollback,

  input  logic [REG_POS_W-1:0] rs1_pos,
  output logic                 rs1_busy,
  output logic [ROB_POS_W-1:0] rs1_rob_pos,
  output logic [DATA_W-1:0]    rs1_val,

  input  logic [REG_POS_W-1:0] rs2_pos,
  output logic                 rs2_busy,
  output logic [ROB_POS_W-1:0] rs2_rob_pos,
  output logic [DATA_W-1:0]    rs2_val,

  input  logic                 issue_en,
  input  logic [REG_POS_W-1:0] issue_rd,
  input  logic [ROB_POS_W-1:0] issue_rob_pos,

  input  logic                 commit_en,
  input  logic [REG_POS_W-1:0] commit_rd,
  input  logic [DATA_W-1:0]    commit_val,
  input  logic [ROB_POS_W-1:0] commit_rob_pos
);

  logic [DATA_W-1:0]    val_q [REG_NUM];
  logic [DATA_W-1:0]    val_d [REG_NUM];
  logic [ROB_POS_W-1:0] tag_q [REG_NUM];
  logic [ROB_POS_W-1:0] tag_d [REG_NUM];
  logic [REG_NUM-1:0]   busy_q;
  logic [REG_NUM-1:0]   busy_d;

  logic commit_wr;
  logic issue_wr;

  assign commit_wr = rdy && commit_en && (commit_rd != '0);
  assign issue_wr  = rdy && issue_en && (issue_rd != '0) && !rollback;

  // Read port 1: x0 forced to zero, matching in-flight commit bypassed.
  always_comb begin
    rs1_busy    = busy_q[rs1_pos];
    rs1_rob_pos = tag_q[rs1_pos];
    rs1_val     = val_q[rs1_pos];
    if (rs1_pos == '0) begin
      rs1_busy    = 1'b0;
      rs1_rob_pos = '0;
      rs1_val     = '0;
    end else if (commit_en && rdy && (commit_rd == rs1_pos) && busy_q[rs1_pos] &&
                 (tag_q[rs1_pos] == commit_rob_pos)) begin
      rs1_busy = 1'b0;
      rs1_val  = commit_val;
    end
  end

  always_comb begin
    rs2_busy    = busy_q[rs2_pos];
    rs2_rob_pos = tag_q[rs2_pos];
    rs2_val     = val_q[rs2_pos];
    if (rs2_pos == '0) begin
      rs2_busy    = 1'b0;
      rs2_rob_pos = '0;
      rs2_val     = '0;
    end else if (commit_en && rdy && (commit_rd == rs2_pos) && busy_q[rs2_pos] &&
                 (tag_q[rs2_pos] == commit_rob_pos)) begin
      rs2_busy = 1'b0;
      rs2_val  = commit_val;
    end
  end

  // Order matters: commit clear first, then rollback/issue override busy and tag.
  always_comb begin
    val_d  = val_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (commit_wr) begin
      val_d[commit_rd] = commit_val;
      if (tag_q[commit_rd] == commit_rob_pos) begin
        busy_d[commit_rd] = 1'b0;
      end
    end
    if (rdy && rollback) begin
      busy_d = '0;
      tag_d  = '{default: '0};
    end else if (issue_wr) begin
      busy_d[issue_rd] = 1'b1;
      tag_d[issue_rd]  = issue_rob_pos;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q  <= '{default: '0};
      tag_q  <= '{default: '0};
      busy_q <= '0;
    end else begin
      val_q  <= val_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed table-driven bench for reg_file: one vector per cycle, outputs checked before the edge.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        rollback;
  logic [4:0]  rs1_pos;
  logic        rs1_busy;
  logic [3:0]  rs1_rob_pos;
  logic [31:0] rs1_val;
  logic [4:0]  rs2_pos;
  logic        rs2_busy;
  logic [3:0]  rs2_rob_pos;
  logic [31:0] rs2_val;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_rob_pos;
  logic        commit_en;
  logic [4:0]  commit_rd;
  logic [31:0] commit_val;
  logic [3:0]  commit_rob_pos;

  int tests;
  int fails;

  reg_file #(
    .REG_NUM   (32),
    .REG_POS_W (5),
    .DATA_W    (32),
    .ROB_POS_W (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rdy            (rdy),
    .rollback       (rollback),
    .rs1_pos        (rs1_pos),
    .rs1_busy       (rs1_busy),
    .rs1_rob_pos    (rs1_rob_pos),
    .rs1_val        (rs1_val),
    .rs2_pos        (rs2_pos),
    .rs2_busy       (rs2_busy),
    .rs2_rob_pos    (rs2_rob_pos),
    .rs2_val        (rs2_val),
    .issue_en       (issue_en),
    .issue_rd       (issue_rd),
    .issue_rob_pos  (issue_rob_pos),
    .commit_en      (commit_en),
    .commit_rd      (commit_rd),
    .commit_val     (commit_val),
    .commit_rob_pos (commit_rob_pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        rb;
    logic        ie;
    logic [4:0]  ird;
    logic [3:0]  irob;
    logic        ce;
    logic [4:0]  crd;
    logic [31:0] cval;
    logic [3:0]  crob;
    logic [4:0]  p1;
    logic [4:0]  p2;
    logic        chk_rob;
    logic        e1b;
    logic [3:0]  e1r;
    logic [31:0] e1v;
    logic        e2b;
    logic [3:0]  e2r;
    logic [31:0] e2v;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL v%0d %s: got 0x%08h, want 0x%08h", idx, name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rdy            = v.rdy;
    rollback       = v.rb;
    issue_en       = v.ie;
    issue_rd       = v.ird;
    issue_rob_pos  = v.irob;
    commit_en      = v.ce;
    commit_rd      = v.crd;
    commit_val     = v.cval;
    commit_rob_pos = v.crob;
    rs1_pos        = v.p1;
    rs2_pos        = v.p2;
  endtask

  initial begin
    vec_t v;
    tests = 0;
    fails = 0;

    // V0-V2: issue x5->3, then matching commit with bypass, then stored value
    vq.push_back('{default:'0, rdy:1, ie:1, ird:5, irob:3, p1:5, chk_rob:1});
    vq.push_back('{default:'0, rdy:1, ce:1, crd:5, cval:32'hDEADBEEF, crob:3, p1:5,
                   e1v:32'hDEADBEEF});
    vq.push_back('{default:'0, rdy:1, p1:5, e1v:32'hDEADBEEF});
    // V3-V6: stale commit leaves younger rename intact, no bypass
    vq.push_back('{default:'0, rdy:1, ie:1, ird:7, irob:2, p1:7, chk_rob:1});
    vq.push_back('{default:'0, rdy:1, ie:1, ird:7, irob:9, p1:7, chk_rob:1, e1b:1, e1r:2});
    vq.push_back('{default:'0, rdy:1, ce:1, crd:7, cval:32'h11, crob:2, p1:7, chk_rob:1,
                   e1b:1, e1r:9});
    vq.push_back('{default:'0, rdy:1, p1:7, chk_rob:1, e1b:1, e1r:9, e1v:32'h11});
    // V7-V9: same-cycle commit and issue on x4
    vq.push_back('{default:'0, rdy:1, ie:1, ird:4, irob:1, p1:7, p2:5, chk_rob:1,
                   e1b:1, e1r:9, e1v:32'h11, e2r:3, e2v:32'hDEADBEEF});
    vq.push_back('{default:'0, rdy:1, ie:1, ird:4, irob:6, ce:1, crd:4, cval:32'h22, crob:1,
                   p1:4, e1v:32'h22});
    vq.push_back('{default:'0, rdy:1, p1:4, chk_rob:1, e1b:1, e1r:6, e1v:32'h22});
    // V10-V14: rollback with concurrent commit and ignored issue
    vq.push_back('{default:'0, rdy:1, ie:1, ird:1, irob:4, p1:1, chk_rob:1});
    vq.push_back('{default:'0, rdy:1, ie:1, ird:2, irob:5, p1:1, p2:2, chk_rob:1, e1b:1, e1r:4});
    vq.push_back('{default:'0, rdy:1, rb:1, ie:1, ird:3, irob:7, ce:1, crd:1, cval:32'h80, crob:4,
                   p1:1, p2:2, e1v:32'h80, e2b:1});
    vq.push_back('{default:'0, rdy:1, p1:1, p2:2, e1v:32'h80});
    vq.push_back('{default:'0, rdy:1, p1:3, p2:4, e2v:32'h22});
    // V15-V18: rdy low freezes state and disables bypass
    vq.push_back('{default:'0, rdy:1, ie:1, ird:6, irob:5, p1:6, chk_rob:1});
    vq.push_back('{default:'0, rdy:1, p1:6, chk_rob:1, e1b:1, e1r:5});
    vq.push_back('{default:'0, rdy:0, rb:1, ie:1, ird:9, irob:8, ce:1, crd:6, cval:32'h77, crob:5,
                   p1:6, p2:9, chk_rob:1, e1b:1, e1r:5});
    vq.push_back('{default:'0, rdy:1, p1:6, p2:9, chk_rob:1, e1b:1, e1r:5});
    // V19-V20: writes to x0 ignored
    vq.push_back('{default:'0, rdy:1, ie:1, ird:0, irob:3, ce:1, crd:0, cval:32'h55, crob:0,
                   chk_rob:1});
    vq.push_back('{default:'0, rdy:1, chk_rob:1});
    // V21-V22: deferred commit of x6 now lands
    vq.push_back('{default:'0, rdy:1, ce:1, crd:6, cval:32'h77, crob:5, p1:6, e1v:32'h77});
    vq.push_back('{default:'0, rdy:1, p1:6, p2:4, chk_rob:1, e1r:5, e1v:32'h77, e2v:32'h22});

    // Reset state, read while reset asserted
    v = '{default:'0, rdy:1, p1:5, p2:0};
    drive(v);
    rst_n = 1'b0;
    #2;
    check("rst rs1_busy", -1, {31'd0, rs1_busy}, 32'd0);
    check("rst rs1_val",  -1, rs1_val, 32'd0);
    check("rst rs2_busy", -1, {31'd0, rs2_busy}, 32'd0);
    check("rst rs2_rob",  -1, {28'd0, rs2_rob_pos}, 32'd0);
    check("rst rs2_val",  -1, rs2_val, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i]);
      #2;
      check("rs1_busy", i, {31'd0, rs1_busy}, {31'd0, vq[i].e1b});
      check("rs1_val",  i, rs1_val, vq[i].e1v);
      check("rs2_busy", i, {31'd0, rs2_busy}, {31'd0, vq[i].e2b});
      check("rs2_val",  i, rs2_val, vq[i].e2v);
      if (vq[i].chk_rob) begin
        check("rs1_rob", i, {28'd0, rs1_rob_pos}, {28'd0, vq[i].e1r});
        check("rs2_rob", i, {28'd0, rs2_rob_pos}, {28'd0, vq[i].e2r});
      end
    end

    // Async reset mid-cycle with busy state present, rdy low
    @(negedge clk);
    v = '{default:'0, rdy:1, ie:1, ird:8, irob:12};
    drive(v);
    @(negedge clk);
    v = '{default:'0, rdy:0, p1:8, p2:4};
    drive(v);
    #1;
    check("pre-arst x8 busy", 100, {31'd0, rs1_busy}, 32'd1);
    check("pre-arst x8 rob",  100, {28'd0, rs1_rob_pos}, 32'd12);
    check("pre-arst x4 val",  100, rs2_val, 32'h22);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst x8 busy", 101, {31'd0, rs1_busy}, 32'd0);
    check("arst x8 rob",  101, {28'd0, rs1_rob_pos}, 32'd0);
    check("arst x4 val",  101, rs2_val, 32'd0);
    #3;
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file with rename tags for the out-of-order core. It sits between decode and commit. Decode reads source operands and renames each destination to its reorder-buffer slot. The reorder buffer's commit port writes retired values back and clears the rename. A rollback discards all outstanding renames.

## Interface
Parameters:
- REG_NUM, 32, number of architectural registers; x0 is hard-wired to zero.
- REG_POS_W, 5, register index width.
- DATA_W, 32, register data width.
- ROB_POS_W, 4, reorder-buffer slot index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- rdy  in  1  global run enable; when low, all state holds.
- rollback  in  1  flush; discards all renames.
- rs1_pos  in  REG_POS_W  source-1 register index.
- rs1_busy  out  1  source 1 is awaiting an in-flight result.
- rs1_rob_pos  out  ROB_POS_W  producer slot for source 1; valid when rs1_busy=1.
- rs1_val  out  DATA_W  source-1 value; valid when rs1_busy=0.
- rs2_pos, rs2_busy, rs2_rob_pos, rs2_val  same directions and widths as rs1, for source 2.
- issue_en  in  1  decode renames a destination this cycle.
- issue_rd  in  REG_POS_W  destination register being renamed.
- issue_rob_pos  in  ROB_POS_W  reorder-buffer slot allocated to the destination.
- commit_en  in  1  retirement write this cycle.
- commit_rd  in  REG_POS_W  retiring destination register.
- commit_val  in  DATA_W  retiring value.
- commit_rob_pos  in  ROB_POS_W  slot of the retiring entry.

## Operation
- State per register: val[DATA_W], busy, tag[ROB_POS_W].
- Reset (rst_n low, asynchronous): every val=0, busy=0, tag=0. Outputs are combinational, so with rs*_pos=0 they read busy=0, rob_pos=0, val=0.

Read path (combinational, per source):
- Index 0: busy=0, val=0, rob_pos=0, always.
- Bypass case: commit_en & rdy & commit_rd==pos & busy[pos] & tag[pos]==commit_rob_pos. Outputs are busy=0 and val=commit_val.
- Otherwise the outputs are busy[pos], tag[pos] and val[pos].

Commit (rdy=1, commit_en=1, commit_rd≠0):
- val[commit_rd] <= commit_val, unconditionally, including during a rollback cycle.
- busy[commit_rd] <= 0 only if tag[commit_rd]==commit_rob_pos. A mismatch means a younger rename exists; the rename is left intact.

Issue (rdy=1, issue_en=1, issue_rd≠0, rollback=0):
- busy[issue_rd] <= 1 and tag[issue_rd] <= issue_rob_pos.
- If issue and commit hit the same register in the same cycle, the issue's busy/tag update wins over the commit's busy clear. The commit's val write still happens.

Rollback (rdy=1, rollback=1):
- All busy <= 0.
- Tags are don't-care afterwards; the implementation clears them to 0.
- issue_en is ignored.
- A same-cycle commit still writes val.

Writes to x0 from either port are ignored.

When rdy=0: no state change, no bypass. Reads show the stored state.

## Timing
- Read latency: 0 cycles (combinational).
- Commit and issue effects become visible on reads in the cycle after the edge.
- Exception: a matching commit is visible on reads in the same cycle, via the bypass.
- Issue does not bypass. A read of issue_rd in the issue cycle returns the pre-issue state; decode handles its own intra-cycle dependency.
- Async reset takes effect immediately mid-operation, regardless of rdy and clk.
- No handshake: the producer guarantees at most one issue and one commit per cycle.

## Test plan
- Reset then read: rst_n low, rs1_pos=5 → busy=0, val=0; with rs2_pos=0 → busy=0, val=0, rob_pos=0.
- Issue x5→slot 3; next cycle read x5 → busy=1, rob_pos=3. Commit x5=0xDEADBEEF, slot 3: same cycle → busy=0, val=0xDEADBEEF; next cycle → stored value, busy=0.
- Stale commit: issue x7→slot 2, then issue x7→slot 9, then commit x7 slot 2, val 0x11 → val=0x11, busy stays 1, rob_pos=9. No bypass in the commit cycle.
- Same cycle, same register: commit x4 slot 1 val 0x22 with busy[4]=1, tag[4]=1, plus issue x4→slot 6 → next cycle busy=1, rob_pos=6, val=0x22.
- Rollback with commit: x1 busy tag 4, x2 busy tag 5; rollback=1 with commit x1 slot 4 val 0x80 and issue x3→slot 7 → next cycle x1/x2/x3 all busy=0, x1 val=0x80, x3 not renamed.
- rdy=0 and x0 checks:
  - rdy=0 with issue_en and commit_en active → no state change and no bypass.
  - Issue x0 or commit x0 val 0x55 → x0 reads busy=0, val=0.
